// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM states, status-register
// bit positions, stop-bit field codes and the legal data-length range.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int STAT_EN      = 0;
  localparam int STAT_LEN_LO  = 1;
  localparam int STAT_LEN_HI  = 4;
  localparam int STAT_PAR     = 5;
  localparam int STAT_STOP_LO = 6;
  localparam int STAT_STOP_HI = 7;

  localparam logic [1:0] STOP_CODE_ONE = 2'b01;
  localparam logic [1:0] STOP_CODE_TWO = 2'b10;

  localparam logic [3:0] LEN_MIN = 4'd5;
  localparam logic [3:0] LEN_MAX = 4'd9;

  localparam int MAX_DATA_W = 9;
  localparam int BUF_W      = 16;

  function automatic logic len_valid(input logic [3:0] len);
    return (len >= LEN_MIN) && (len <= LEN_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_oversampler.sv
// Oversample tick generator: counts 0..divisor and pulses tick on the last
// count, so a tick occurs every divisor+1 clocks. clear restarts the count.
module uart_rx_oversampler (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] divisor,
  input  logic        clear,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;
  logic        at_top;

  // >= rather than == so a divisor lowered mid-count still wraps promptly
  assign at_top = (cnt_q >= divisor);
  assign tick   = at_top;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (clear || at_top) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: RX synchronizer, start/bit framing FSM sampling mid-bit on
// the oversample tick, LSB-first shift register, parity/stop/overrun flags.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Baud_Rate_Holding_Register,
  input  logic [15:0]      Receiver_Status,
  input  logic             RX,
  input  logic             rx_read,
  output logic [BUF_W-1:0] Receiver_Buffer_Register,
  output logic             rx_valid,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overrun_error
);

  localparam int              PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  rx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             len_q, len_d;
  logic                   par_en_q, par_en_d;
  logic                   two_stop_q, two_stop_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [MAX_DATA_W-1:0]  shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   stop_err_q, stop_err_d;
  logic [BUF_W-1:0]       buf_q, buf_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;

  logic       tick, rx_s, en, start_go, sample, complete, fe_now;
  logic [3:0] cfg_len;
  logic [7:0] unused_status;

  assign rx_s          = sync_q[SYNC_STAGES-1];
  assign en            = Receiver_Status[STAT_EN];
  assign cfg_len       = Receiver_Status[STAT_LEN_HI:STAT_LEN_LO];
  assign unused_status = Receiver_Status[15:8];

  // Edge-based start detect: after a break the line must return high first
  assign start_go = en && (state_q == ST_IDLE) && rx_prev_q && !rx_s && len_valid(cfg_len);
  assign sample   = tick && (phase_q == PH_MID);

  uart_rx_oversampler u_oversampler (
    .clk     (clk),
    .rst     (rst),
    .divisor (Baud_Rate_Holding_Register),
    .clear   (start_go || !en),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], RX};
    rx_prev_d  = rx_s;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    buf_d      = buf_q;
    valid_d    = valid_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    ovr_d      = ovr_q;
    complete   = 1'b0;
    fe_now     = stop_err_q | ~rx_s;

    if (tick && (state_q != ST_IDLE))
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

    if (!en) begin
      state_d   = ST_IDLE;
      phase_d   = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_go) begin
            state_d    = ST_START;
            phase_d    = '0;
            bit_cnt_d  = '0;
            len_d      = cfg_len;
            par_en_d   = Receiver_Status[STAT_PAR];
            two_stop_d = (Receiver_Status[STAT_STOP_HI:STAT_STOP_LO] == STOP_CODE_TWO);
            stop_idx_d = 1'b0;
            shift_d    = '0;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
          end
        end
        ST_START: begin
          if (sample) state_d = rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (sample) begin
            shift_d[bit_cnt_q] = rx_s;
            if (bit_cnt_q == len_q - 4'd1) begin
              bit_cnt_d = '0;
              state_d   = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (sample) begin
            par_err_d = (^shift_q) ^ rx_s;
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            stop_err_d = fe_now;
            if (!two_stop_q || stop_idx_q) begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A completion wins over a read; a coincident read suppresses overrun
    if (complete) begin
      buf_d   = {{(BUF_W - MAX_DATA_W){1'b0}}, shift_q};
      valid_d = 1'b1;
      pe_d    = par_err_q;
      fe_d    = fe_now;
      ovr_d   = valid_q && !rx_read;
    end else if (rx_read) begin
      valid_d = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign Receiver_Buffer_Register = buf_q;
  assign rx_valid                 = valid_q;
  assign parity_error             = pe_q;
  assign framing_error            = fe_q;
  assign overrun_error            = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected words,
// a monitor compares each word the receiver presents.
module tb_uart_receiver;

  localparam int D        = 3;
  localparam int BIT_CLKS = 16 * (D + 1);

  localparam logic [15:0] CFG_8N1  = 16'h0051;
  localparam logic [15:0] CFG_7P1  = 16'h006F;
  localparam logic [15:0] CFG_8N2  = 16'h0091;
  localparam logic [15:0] CFG_9N1  = 16'h0053;
  localparam logic [15:0] CFG_LEN4 = 16'h0049;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] baud;
  logic [15:0] status;
  logic        RX;
  logic        rx_read;
  logic [15:0] rbr;
  logic        rx_valid, parity_error, framing_error, overrun_error;

  typedef struct packed {
    logic [15:0] data;
    logic        pe;
    logic        fe;
    logic        ovr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk                        (clk),
    .rst                        (rst),
    .Baud_Rate_Holding_Register (baud),
    .Receiver_Status            (status),
    .RX                         (RX),
    .rx_read                    (rx_read),
    .Receiver_Buffer_Register   (rbr),
    .rx_valid                   (rx_valid),
    .parity_error               (parity_error),
    .framing_error              (framing_error),
    .overrun_error              (overrun_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a word is presented when rx_valid rises or the word/flags change while valid
  initial begin : monitor
    exp_t cur, prev, e;
    logic prev_valid;
    prev       = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cur = {rbr, parity_error, framing_error, overrun_error};
      if (rst && rx_valid && (!prev_valid || cur != prev)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", cur);
        end else begin
          e = sb.pop_front();
          check("word_data", {16'h0, cur.data}, {16'h0, e.data});
          check("parity_error", {31'h0, cur.pe}, {31'h0, e.pe});
          check("framing_error", {31'h0, cur.fe}, {31'h0, e.fe});
          check("overrun_error", {31'h0, cur.ovr}, {31'h0, e.ovr});
        end
      end
      prev       = cur;
      prev_valid = rx_valid;
    end
  end

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                            input logic par_bit, input int nstops, input logic stop2);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(data[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(1'b1);
    if (nstops == 2) drive_bit(stop2);
  endtask

  task automatic pulse_read();
    @(posedge clk); #1;
    rx_read = 1'b1;
    @(posedge clk); #1;
    rx_read = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {31'h0, rx_valid}, 32'h0);
    check({tag, "_buffer"}, {16'h0, rbr}, 32'h0);
    check({tag, "_pe"}, {31'h0, parity_error}, 32'h0);
    check({tag, "_fe"}, {31'h0, framing_error}, 32'h0);
    check({tag, "_ovr"}, {31'h0, overrun_error}, 32'h0);
  endtask

  initial begin : stimulus
    rst     = 1'b0;
    RX      = 1'b1;
    rx_read = 1'b0;
    baud    = 32'(D);
    status  = 16'h0;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst    = 1'b1;
    status = CFG_8N1;
    idle_bits(1);

    // 8N1 0xA5
    sb.push_back({16'h00A5, 3'b000});
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    idle_bits(1);
    pulse_read();
    check("read_clears_valid", {31'h0, rx_valid}, 32'h0);

    // 7 data bits, even parity: 0x35 has four ones, so parity bit 1 is wrong
    status = CFG_7P1;
    idle_bits(1);
    sb.push_back({16'h0035, 3'b100});
    send_frame(9'h035, 7, 1, 1'b1, 1, 1'b1);
    idle_bits(1);
    pulse_read();
    check("read_clears_pe", {31'h0, parity_error}, 32'h0);
    sb.push_back({16'h0035, 3'b000});
    send_frame(9'h035, 7, 1, 1'b0, 1, 1'b1);
    idle_bits(1);
    pulse_read();

    // 8N2 with second stop bit 0, then a held break
    status = CFG_8N2;
    idle_bits(1);
    sb.push_back({16'h003C, 3'b010});
    send_frame(9'h03C, 8, 0, 1'b0, 2, 1'b0);
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    pulse_read();
    check("break_read_clears_fe", {31'h0, framing_error}, 32'h0);
    repeat (12 * BIT_CLKS) @(posedge clk);
    #1;
    check("break_no_start", {31'h0, rx_valid}, 32'h0);
    idle_bits(2);
    sb.push_back({16'h005A, 3'b000});
    send_frame(9'h05A, 8, 0, 1'b0, 2, 1'b1);
    idle_bits(1);
    pulse_read();

    // Invalid length field: frame ignored
    status = CFG_LEN4;
    idle_bits(1);
    send_frame(9'h00F, 8, 0, 1'b0, 1, 1'b1);
    idle_bits(2);
    check("bad_len_ignored", {31'h0, rx_valid}, 32'h0);

    // Two frames without a read -> overrun
    status = CFG_8N1;
    idle_bits(1);
    sb.push_back({16'h0011, 3'b000});
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1);
    sb.push_back({16'h0022, 3'b001});
    send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1);
    idle_bits(1);
    pulse_read();
    check("overrun_read_valid", {31'h0, rx_valid}, 32'h0);
    check("overrun_read_ovr", {31'h0, overrun_error}, 32'h0);

    // Start glitch of 4 ticks
    RX = 1'b0;
    repeat (4 * (D + 1)) @(posedge clk);
    #1;
    idle_bits(2);
    check("glitch_no_word", {31'h0, rx_valid}, 32'h0);
    sb.push_back({16'h003C, 3'b000});
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1);
    idle_bits(1);
    check("glitch_recovery_valid", {31'h0, rx_valid}, 32'h1);

    // 9-bit frame 0x1FF interrupted by reset mid-DATA
    status = CFG_9N1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("midframe_reset");
    RX  = 1'b1;
    rst = 1'b1;
    idle_bits(2);
    sb.push_back({16'h0055, 3'b000});
    send_frame(9'h055, 9, 0, 1'b0, 1, 1'b1);
    idle_bits(1);
    pulse_read();

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
